// File: rtl/sample_sequencer.sv
// Launches one filter job at a time from a small sample FIFO and holds the result for downstream.
// Build option: define SEQ_TIMEOUT_EN to flag (sticky err) and abandon a job whose srdyo never arrives.
module sample_sequencer #(
  parameter int DW      = 16,
  parameter int RW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 220
) (
  input  logic          clk,
  input  logic          GlobalReset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          srdyi,
  output logic [DW-1:0] sample_out,
  input  logic          srdyo,
  input  logic [RW-1:0] result_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic          busy,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} stateT;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  stateT         r_state;
  logic          r_srdyi;
  logic [DW-1:0] r_sample;
  logic          r_outValid;
  logic [RW-1:0] r_outData;
  logic [7:0]    r_waitCnt;
  logic          r_err;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_launch;
  logic w_timeoutHit;

  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = in_valid && !w_full;
  assign w_launch     = (r_state == S_IDLE) && !w_empty && (!r_outValid || out_ready);
  assign w_timeoutHit = (r_waitCnt == 8'(TIMEOUT - 1));

  assign in_ready   = !w_full;
  assign srdyi      = r_srdyi;
  assign sample_out = r_sample;
  assign out_valid  = r_outValid;
  assign out_data   = r_outData;
  assign busy       = (r_state == S_WAIT);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // Pointers wrap on their own; the extra count bit separates full from empty.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_launch) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_launch})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_state    <= S_IDLE;
      r_srdyi    <= 1'b0;
      r_sample   <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_waitCnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_srdyi <= 1'b0;
      if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state   <= S_WAIT;
            r_sample  <= r_mem[r_rptr];
            r_srdyi   <= 1'b1;
            r_waitCnt <= '0;
          end
        end
        S_WAIT: begin
          if (r_waitCnt != 8'hFF) begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
          // A result on the timeout edge still counts as success.
          if (srdyo) begin
            r_outData  <= result_in;
            r_outValid <= 1'b1;
            r_state    <= S_IDLE;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (w_timeoutHit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  assign err = r_err;
`else
  logic w_unused;
  assign w_unused = &{1'b0, w_timeoutHit, r_err};
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_sample_sequencer.sv
// Randomized and directed bench for sample_sequencer with a queue-based reference model.
// Honours SEQ_TIMEOUT_EN the same way the design does.
module tb_sample_sequencer;

  localparam int DW      = 16;
  localparam int RW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 220;
  localparam int LAT     = 197;

  logic          clk = 1'b0;
  logic          GlobalReset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          srdyi;
  logic [DW-1:0] sample_out;
  logic          srdyo = 1'b0;
  logic [RW-1:0] result_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic          busy;
  logic          err;

  sample_sequencer #(.DW(DW), .RW(RW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .srdyi(srdyi), .sample_out(sample_out),
    .srdyo(srdyo), .result_in(result_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int            pushRate = 0;
  int            readyRate = 0;
  bit            useFixedData = 1'b0;
  logic [DW-1:0] fixedData = '0;
  bit            useFixedResult = 1'b0;
  logic [RW-1:0] fixedResult = '0;
  bit            withhold = 1'b0;
  bit            spurious = 1'b0;
  bit            resetReq = 1'b1;
  bit            checkEn = 1'b0;
  int            cyc = 0;
  int            fireCycle = -1;

  // Reference model: the FIFO is a queue, the filter job is a busy flag plus an elapsed-cycle count.
  logic [DW-1:0] mq [$];
  bit            mBusy = 1'b0;
  int            mWait = 0;
  bit            mSrdyi = 1'b0;
  logic [DW-1:0] mSample = '0;
  bit            mOutValid = 1'b0;
  logic [RW-1:0] mOutData = '0;
  bit            mErr = 1'b0;
  int            mSize;
  bit            mLaunch;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs per iteration; also plays the filter, answering each srdyi LAT cycles later.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (srdyi === 1'b1 && !withhold) fireCycle = cyc + LAT;
      srdyo       = (cyc == fireCycle) || spurious;
      result_in   = useFixedResult ? fixedResult : RW'($urandom);
      in_valid    = (int'($urandom_range(99)) < pushRate);
      in_data     = useFixedData ? fixedData : DW'($urandom);
      out_ready   = (int'($urandom_range(99)) < readyRate);
      GlobalReset = resetReq;
    end
  endtask

  always @(posedge clk) begin
    if (GlobalReset) begin
      mq.delete();
      mBusy = 1'b0; mWait = 0; mSrdyi = 1'b0; mSample = '0;
      mOutValid = 1'b0; mOutData = '0; mErr = 1'b0;
    end else begin
      mSize   = mq.size();
      mLaunch = !mBusy && (mSize > 0) && (!mOutValid || out_ready);
      if (mOutValid && out_ready) mOutValid = 1'b0;
      if (mBusy) begin
        mWait++;
        if (srdyo) begin
          mOutData  = result_in;
          mOutValid = 1'b1;
          mBusy     = 1'b0;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (mWait == TIMEOUT) begin
          mErr  = 1'b1;
          mBusy = 1'b0;
        end
`endif
      end
      if (mLaunch) begin
        mSample = mq.pop_front();
        mBusy   = 1'b1;
        mWait   = 0;
      end
      mSrdyi = mLaunch;
      if (in_valid && mSize < DEPTH) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("in_ready",   in_ready,   (mq.size() < DEPTH));
      checkOutput("srdyi",      srdyi,      mSrdyi);
      checkOutput("sample_out", sample_out, mSample);
      checkOutput("out_valid",  out_valid,  mOutValid);
      checkOutput("out_data",   out_data,   mOutData);
      checkOutput("busy",       busy,       mBusy);
      checkOutput("err",        err,        mErr);
    end
  end

  initial begin
    int srdyiCyc;
    int launches;
    int firstLaunch;
    int secondLaunch;

    // Reset and idle state.
    applyStimulus(2);
    resetReq = 1'b0;
    applyStimulus(1);
    checkEn = 1'b1;
    checkOutput("rst_srdyi", srdyi, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    // Single sample through the full round trip.
    $display("[TB] single job latency");
    useFixedData = 1'b1; fixedData = 16'h0100; pushRate = 100;
    applyStimulus(1);
    pushRate = 0;
    applyStimulus(2);
    srdyiCyc = cyc;
    checkOutput("t1_srdyi_high", srdyi, 1);
    checkOutput("t1_sample_out", sample_out, 16'h0100);
    useFixedResult = 1'b1; fixedResult = 32'h00001234;
    applyStimulus(1);
    checkOutput("t1_srdyi_pulse", srdyi, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1);
      if (out_valid === 1'b1) break;
    end
    checkOutput("t1_latency", cyc - srdyiCyc, LAT + 1);
    checkOutput("t1_out_data", out_data, 32'h00001234);
    useFixedResult = 1'b0; useFixedData = 1'b0;

    // Fill the FIFO behind an in-flight job, then drain back-to-back.
    $display("[TB] fifo fill and back-to-back drain");
    readyRate = 100; pushRate = 100;
    applyStimulus(7);
    checkOutput("t2_full", in_ready, 0);
    pushRate = 0;
    launches = 0; firstLaunch = 0; secondLaunch = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1);
      if (srdyi === 1'b1) begin
        launches++;
        if (launches == 1) firstLaunch = cyc;
        if (launches == 2) secondLaunch = cyc;
      end
    end
    checkOutput("t2_launches", launches, 4);
    checkOutput("t2_gap", secondLaunch - firstLaunch, LAT + 2);
    applyStimulus(250);
    checkOutput("t2_empty", in_ready, 1);

    // Held result blocks the next launch until accepted.
    $display("[TB] output backpressure");
    readyRate = 0; pushRate = 100;
    applyStimulus(2);
    pushRate = 0;
    applyStimulus(420);
    checkOutput("t3_held", out_valid, 1);
    launches = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      if (srdyi === 1'b1) launches++;
    end
    checkOutput("t3_no_launch", launches, 0);
    readyRate = 100;
    applyStimulus(1);
    readyRate = 0;
    applyStimulus(1);
    checkOutput("t3_launch", srdyi, 1);
    checkOutput("t3_accepted", out_valid, 0);

    // Reset in the middle of a job; the stale srdyo must be ignored.
    $display("[TB] reset during wait");
    applyStimulus(99);
    resetReq = 1'b1;
    applyStimulus(1);
    resetReq = 1'b0;
    applyStimulus(1);
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_out_data", out_data, 0);
    checkOutput("t4_sample_out", sample_out, 0);
    checkOutput("t4_in_ready", in_ready, 1);
    applyStimulus(150);
    checkOutput("t4_late_ignored", out_valid, 0);

    // srdyo while idle.
    $display("[TB] spurious srdyo");
    spurious = 1'b1;
    applyStimulus(1);
    spurious = 1'b0;
    applyStimulus(3);
    checkOutput("t5_out_valid", out_valid, 0);
    checkOutput("t5_busy", busy, 0);

    // Missing srdyo.
    $display("[TB] withheld srdyo");
    withhold = 1'b1; pushRate = 100;
    applyStimulus(1);
    pushRate = 0;
    applyStimulus(2);
`ifdef SEQ_TIMEOUT_EN
    applyStimulus(TIMEOUT + 5);
    checkOutput("t6_err", err, 1);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_out_valid", out_valid, 0);
    spurious = 1'b1;
    applyStimulus(1);
    spurious = 1'b0;
    applyStimulus(2);
    checkOutput("t6_late_ignored", out_valid, 0);
`else
    applyStimulus(1000);
    checkOutput("t6_busy", busy, 1);
    checkOutput("t6_err", err, 0);
`endif
    withhold = 1'b0;
    resetReq = 1'b1;
    applyStimulus(1);
    resetReq = 1'b0;
    applyStimulus(1);
    checkOutput("t6_reset_err", err, 0);

    // Random traffic against the model.
    $display("[TB] random traffic");
    pushRate = 35; readyRate = 60;
    applyStimulus(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
